bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial converter feeding the serial sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which connects directly to the detector's `din`. A one-word holding register lets consecutive words stream with no idle gap between them. Between words, `dout` sits at a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
- `IDLE_BIT`, 0: level driven on `dout` when no word is shifting.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in WIDTH: word to serialize; sampled on accept.
- `load_valid` in 1: `data_in` is valid.
- `load_ready` out 1: block can accept a word this cycle.
- `flush` in 1: synchronous abort; discards the shifting word and the held word.
- `dout` out 1: serial bit stream, goes to detector `din`.
- `dout_valid` out 1: `dout` carries a data bit (not idle fill).
- `frame_start` out 1: high during the first bit of each word.
- `busy` out 1: shifting, or holding register full.

## Operation
- Accept condition: `load_valid && load_ready` at a rising edge.
- `load_ready` is `!hold_full && !flush && !rst`.
- State machine has two states.
  - IDLE: `dout`=IDLE_BIT, `dout_valid`=0.
  - SHIFT: `dout` is the current output bit of the shift register, `dout_valid`=1.
- Bit counter `cnt` is $clog2(WIDTH) bits wide. It runs 0..WIDTH-1 in SHIFT and is 0 in IDLE.
- Accept in IDLE:
  - word loads directly into the shift register;
  - state goes to SHIFT with `cnt`=0.
- Accept in SHIFT with `cnt`=WIDTH-1 (last bit on `dout`): word loads directly into the shift register and `cnt` returns to 0, giving a seamless frame.
- Accept in SHIFT with `cnt` < WIDTH-1: word is written to the holding register and `hold_full` is set to 1.
- End of frame (SHIFT, `cnt`=WIDTH-1, rising edge):
  - if `hold_full`: holding register moves to the shift register, `hold_full` clears, `cnt` becomes 0, state stays SHIFT;
  - otherwise, if an accept occurs this edge, take the direct-load path above;
  - otherwise go to IDLE.
- An accept cannot coincide with a hold→shift transfer, because `load_ready` is 0 while `hold_full` is set.
- Shift direction:
  - MSB_FIRST=1: `dout` = sreg[WIDTH-1]; register shifts left each cycle.
  - MSB_FIRST=0: `dout` = sreg[0]; register shifts right each cycle.
  - Fill bits shifted in are don't-care and never appear on `dout`.
- `frame_start` = SHIFT && `cnt`==0.
- `busy` = SHIFT || `hold_full`.
- `flush`:
  - takes priority over every other event except `rst`;
  - next cycle: state IDLE, `cnt`=0, `hold_full`=0, `dout`=IDLE_BIT;
  - any in-progress word is truncated and no accept occurs that edge.
- Reset values (`rst` high at an edge):
  - state IDLE, `cnt`=0, `hold_full`=0;
  - `dout`=IDLE_BIT, `dout_valid`=0, `frame_start`=0, `busy`=0;
  - `load_ready`=0 while `rst` is high, 1 on the first cycle after release.
- Reset asserted mid-word: the word is lost and `dout` returns to IDLE_BIT after that edge.

## Timing
- Latency: word accepted at edge E in IDLE → first bit on `dout` in the cycle after E.
- Last bit of that word is driven through edge E+WIDTH.
- Throughput: one bit per clock.
- Back-to-back words have zero idle cycles while the producer keeps `load_valid` high and the holding register is refilled before each frame ends.
- `load_ready` drops in the cycle after a held accept and rises in the cycle after the hold→shift transfer.
- All outputs are derived from registers only; no combinational path from `data_in` to `dout`.
- `load_ready` depends combinationally on `flush` and `rst`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `load_valid`=1 → `load_ready`=0, `dout`=0, `busy`=0; first cycle after release `load_ready`=1.
- **Single word:** WIDTH=8, MSB_FIRST=1, accept 0xA5 from IDLE →
  - `dout` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept;
  - `frame_start` high on the first bit only;
  - then `dout_valid`=0 and `dout`=0.
- **Streaming:** keep `load_valid` high with 0x55 then 0x0F →
  - 16 consecutive valid bits, no gap;
  - `frame_start` high exactly 8 cycles apart;
  - `load_ready` low while `hold_full`.
- **LSB-first:** MSB_FIRST=0, accept 0x01 → `dout` = 1 followed by seven 0s.
- **Flush:** assert `flush` on the 4th bit of 0xFF while a second word is held → next cycle `dout`=0, `dout_valid`=0, `busy`=0; held word never appears.
- **Last-bit accept:** in IDLE-with-no-hold conditions, present a new word exactly during `cnt`=7 → it is accepted directly and its first bit follows with no gap, `frame_start`=1.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word-load handshake between a producer and the bit serializer.
// A word transfers on a rising clk edge where load_valid && load_ready; the producer
// holds data_in/load_valid stable until that edge, and load_ready never depends on load_valid.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that consecutive
// words stream out without idle cycles; dout feeds the sequence detector's din.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serializer_if.slave      bus,
  input  logic                 flush,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 frame_start,
  output logic                 busy,
  output logic                 state_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;
  logic             last_bit;

  assign bus.load_ready = !hold_full_q && !flush && !rst;
  assign accept         = bus.load_valid && bus.load_ready;
  assign last_bit       = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_d  = bus.data_in;
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt_d = '0;
            // A held word always wins; accept is impossible while hold is full.
            if (hold_full_q) begin
              sreg_d      = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              sreg_d = bus.data_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            if (accept) begin
              hold_d      = bus.data_in;
              hold_full_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Outputs come from registered state only.
  assign dout        = (state_q == SHIFT) ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]) : IDLE_BIT;
  assign dout_valid  = (state_q == SHIFT);
  assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign busy        = (state_q == SHIFT) || hold_full_q;
  assign state_o     = (state_q == SHIFT);
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance, a driver task,
// and negedge monitors that pop expected {frame_start, dout} pairs from queues.
module tb_bit_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic m_flush, l_flush;
  logic m_dout, m_dout_valid, m_frame_start, m_busy, m_state;
  logic l_dout, l_dout_valid, l_frame_start, l_busy, l_state;

  bit_serializer_if #(.WIDTH(8)) m_if ();
  bit_serializer_if #(.WIDTH(8)) l_if ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bus(m_if), .flush(m_flush),
    .dout(m_dout), .dout_valid(m_dout_valid), .frame_start(m_frame_start),
    .busy(m_busy), .state_o(m_state)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(l_if), .flush(l_flush),
    .dout(l_dout), .dout_valid(l_dout_valid), .frame_start(l_frame_start),
    .busy(l_busy), .state_o(l_state)
  );

  logic [1:0] exp_msb_q[$];
  logic [1:0] exp_lsb_q[$];
  int n_checks = 0;
  int errors   = 0;
  int cyc      = 0;
  int run_len  = 0;
  int max_run  = 0;
  int fs_last  = 0;
  int fs_gap   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input bit sel, input logic [7:0] w);
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      e[0] = sel ? w[i] : w[7-i];
      e[1] = (i == 0);
      if (sel) exp_lsb_q.push_back(e);
      else     exp_msb_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word (sel=1 targets the LSB-first instance); returns 1 time unit after the accept edge.
  task automatic send(input bit sel, input logic [7:0] w, input bit keep);
    bit done;
    done = 1'b0;
    if (sel) begin l_if.data_in = w; l_if.load_valid = 1'b1; end
    else     begin m_if.data_in = w; m_if.load_valid = 1'b1; end
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if ((sel ? l_if.load_ready : m_if.load_ready) === 1'b1) begin
        push_word(sel, w);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      errors++;
      $display("FAIL send_timeout: word %0h got no load_ready, required 1", w);
    end
    if (!keep) begin
      if (sel) l_if.load_valid = 1'b0;
      else     m_if.load_valid = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_dout_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_msb_q.size() == 0) chk("msb_unexpected_bit", {30'd0, m_frame_start, m_dout}, 32'hFF);
        else begin
          e = exp_msb_q.pop_front();
          chk("msb_bit", {30'd0, m_frame_start, m_dout}, {30'd0, e});
        end
      end else run_len = 0;
      if (m_frame_start === 1'b1) begin
        fs_gap  = cyc - fs_last;
        fs_last = cyc;
      end
      if (l_dout_valid === 1'b1) begin
        if (exp_lsb_q.size() == 0) chk("lsb_unexpected_bit", {30'd0, l_frame_start, l_dout}, 32'hFF);
        else begin
          e = exp_lsb_q.pop_front();
          chk("lsb_bit", {30'd0, l_frame_start, l_dout}, {30'd0, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_flush = 1'b0; l_flush = 1'b0;
    m_if.data_in = 8'h00; m_if.load_valid = 1'b1;
    l_if.data_in = 8'h00; l_if.load_valid = 1'b0;

    // Reset held 3 cycles with load_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst_load_ready", {31'd0, m_if.load_ready}, 32'd0);
      chk("rst_dout", {31'd0, m_dout}, 32'd0);
      chk("rst_busy", {31'd0, m_busy}, 32'd0);
      chk("rst_dout_valid", {31'd0, m_dout_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.load_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_load_ready", {31'd0, m_if.load_ready}, 32'd1);
    chk("post_rst_frame_start", {31'd0, m_frame_start}, 32'd0);
    tick();

    // Single word 0xA5
    send(1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    chk("single_busy", {31'd0, m_busy}, 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("single_idle_valid", {31'd0, m_dout_valid}, 32'd0);
    chk("single_idle_dout", {31'd0, m_dout}, 32'd0);
    chk("single_idle_busy", {31'd0, m_busy}, 32'd0);
    repeat (3) tick();

    // Streaming 0x55 then 0x0F with load_valid held high
    max_run = 0;
    send(1'b0, 8'h55, 1'b1);
    send(1'b0, 8'h0F, 1'b0);
    @(negedge clk);
    chk("stream_ready_held", {31'd0, m_if.load_ready}, 32'd0);
    chk("stream_busy_held", {31'd0, m_busy}, 32'd1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("stream_run_len", max_run, 32'd16);
    chk("stream_fs_gap", fs_gap, 32'd8);
    chk("stream_end_valid", {31'd0, m_dout_valid}, 32'd0);
    chk("stream_end_ready", {31'd0, m_if.load_ready}, 32'd1);
    repeat (3) tick();

    // Accept presented exactly during the last bit (cnt=7)
    max_run = 0;
    send(1'b0, 8'h3C, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    send(1'b0, 8'hC3, 1'b0);
    @(negedge clk);
    chk("lastbit_direct_ready", {31'd0, m_if.load_ready}, 32'd1);
    chk("lastbit_frame_start", {31'd0, m_frame_start}, 32'd1);
    repeat (9) tick();
    chk("lastbit_run_len", max_run, 32'd16);
    repeat (3) tick();

    // Flush on the 4th bit of 0xFF with 0x81 held
    send(1'b0, 8'hFF, 1'b1);
    send(1'b0, 8'h81, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    m_flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", {31'd0, m_if.load_ready}, 32'd0);
    @(posedge clk);
    #1;
    m_flush = 1'b0;
    exp_msb_q.delete();
    @(negedge clk);
    chk("flush_dout", {31'd0, m_dout}, 32'd0);
    chk("flush_dout_valid", {31'd0, m_dout_valid}, 32'd0);
    chk("flush_busy", {31'd0, m_busy}, 32'd0);
    chk("flush_ready", {31'd0, m_if.load_ready}, 32'd1);
    repeat (12) tick();

    // LSB-first instance: 0x01
    send(1'b1, 8'h01, 1'b0);
    repeat (10) tick();
    chk("lsb_idle_valid", {31'd0, l_dout_valid}, 32'd0);

    chk("msb_queue_drained", exp_msb_q.size(), 32'd0);
    chk("lsb_queue_drained", exp_lsb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
